// File: rtl/servo_pwm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : servo_pkg
// Brief    : Shared types, default timing constants and the pulse-width
//            helper for the servo PWM generator and its timebase front end.
// Revision : 1.0 - initial release
// ============================================================================
package servo_pkg;

  // Default timing: 20 ms frame, 1.0 ms .. 2.0 ms pulse span at a 1 us tick.
  localparam int DEF_FRAME_TICKS = 20000;
  localparam int DEF_MIN_TICKS   = 1000;
  localparam int DEF_MAX_TICKS   = 2000;
  localparam int DEF_POS_WIDTH   = 8;

  // Widest product the width helper can form without losing bits.
  localparam int MAX_PROD_W      = 64;

  // FSM encodings, kept as plain constants so older tools can share them.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } servo_state_e;

  // Pulse width in ticks for a position code:
  //   MIN + ((pos * SPAN) >> POS_WIDTH)
  // The product is formed at full width before the shift so that the top
  // code lands just under MAX rather than wrapping.
  function automatic logic [63:0] servo_width(
    input logic [63:0] pos_v,
    input logic [63:0] min_ticks,
    input logic [63:0] span,
    input int          pos_width
  );
    logic [63:0] prod;
    prod = pos_v * span;
    return min_ticks + (prod >> pos_width);
  endfunction

endpackage : servo_pkg
`default_nettype wire

// File: rtl/servo_pwm_gen_tick_sync.sv
`default_nettype none
// ============================================================================
// Module   : tick_sync
// Brief    : Brings the clock divider's square wave into the in_clk domain
//            through a two-flop synchroniser and emits a one-cycle tick on
//            every rising edge. Usable by any divider consumer.
// Revision : 1.0 - initial release
// ============================================================================
module tick_sync (
  input  logic in_clk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  // sync_q[0] is the metastability catcher, sync_q[1] the first safe copy.
  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronise the divider output and keep one cycle of history for edges.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  // A low-to-high step of the synchronised wave is one tick, one cycle wide.
  assign tick = sync_q[1] & ~prev_q;

endmodule : tick_sync
`default_nettype wire

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_gen
// Brief    : Servo PWM generator. Counts divider ticks into fixed frames and
//            drives a pulse whose width follows an 8-bit position. New
//            positions arrive over valid/ready into a shadow register and
//            are only applied at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int FRAME_TICKS = DEF_FRAME_TICKS,
  parameter int MIN_TICKS   = DEF_MIN_TICKS,
  parameter int MAX_TICKS   = DEF_MAX_TICKS,
  parameter int POS_WIDTH   = DEF_POS_WIDTH
) (
  input  logic                 in_clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 tick_clk,
  input  logic [POS_WIDTH-1:0] pos,
  input  logic                 pos_valid,
  output logic                 pos_ready,
  output logic                 servo_pwm,
  output logic                 frame_start
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int SPAN   = MAX_TICKS - MIN_TICKS;
  localparam int CNT_W  = $clog2(FRAME_TICKS);
  localparam int PROD_W = POS_WIDTH + $clog2(SPAN + 1);

  // Last counter value of a frame; the next tick wraps to zero.
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_TICKS - 1);
  // Mid-span width used until the first position is applied.
  localparam logic [CNT_W-1:0] RST_WIDTH = CNT_W'(MIN_TICKS + (SPAN >> 1));

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  if (MAX_TICKS <= MIN_TICKS) begin : g_err_span
    $fatal(1, "servo_pwm_gen: MAX_TICKS must exceed MIN_TICKS");
  end

  if (FRAME_TICKS <= MAX_TICKS) begin : g_err_frame
    $fatal(1, "servo_pwm_gen: FRAME_TICKS must exceed MAX_TICKS");
  end

  if (PROD_W > MAX_PROD_W) begin : g_err_prod
    $fatal(1, "servo_pwm_gen: position x span product too wide");
  end

  // --------------------------------------------------------------------------
  // Timebase: synchronised rising edges of the divider output
  // --------------------------------------------------------------------------
  logic tick;

  tick_sync u_tick_sync (
    .in_clk   (in_clk),
    .reset    (reset),
    .async_in (tick_clk),
    .tick     (tick)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  servo_state_e     state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] active_q,  active_d;
  logic [CNT_W-1:0] shadow_q,  shadow_d;
  logic             pending_q, pending_d;
  logic             pwm_q,     pwm_d;
  logic             fs_q,      fs_d;

  // Requested width for the position on the bus. Every legal width is below
  // FRAME_TICKS, so it always fits in the counter width.
  logic [CNT_W-1:0] width_new;
  logic             xfer;

  assign width_new = CNT_W'(servo_width(64'(pos), 64'(MIN_TICKS),
                                        64'(SPAN), POS_WIDTH));
  assign xfer      = pos_valid & ~pending_q;

  // Frame sequencing: idle/run control, tick counting and the pulse compare.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fs_d    = 1'b0;
    pwm_d   = 1'b0;
    if (!enable) begin
      // Dropping enable wins over a coincident tick and parks everything.
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      // Pulse is compared against the current count, so it trails by a cycle.
      pwm_d = (state_q == RUN) && (cnt_q < active_q);
      if (tick) begin
        case (state_q)
          IDLE: begin
            state_d = RUN;
            cnt_d   = '0;
            fs_d    = 1'b1;
          end
          RUN: begin
            if (cnt_q == LAST_CNT) begin
              cnt_d = '0;
              fs_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Shadow/handshake: apply a pending width at a frame start, accept new ones.
  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (fs_d && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // A transfer only happens while nothing is pending, so it never collides
    // with the apply above; one arriving on a frame start waits a full frame.
    if (xfer) begin
      shadow_d  = width_new;
      pending_d = 1'b1;
    end
  end

  // Frame control and counter registers.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Width registers; a reset discards whatever was waiting in the shadow.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      active_q  <= RST_WIDTH;
      shadow_q  <= RST_WIDTH;
      pending_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  // Registered outputs so the servo drive and frame marker are glitch free.
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      pwm_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
      fs_q  <= fs_d;
    end
  end

  assign pos_ready   = ~pending_q;
  assign servo_pwm   = pwm_q;
  assign frame_start = fs_q;

endmodule : servo_pwm_gen
`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_gen
// Brief    : Self-checking bench for servo_pwm_gen with a behavioural model
//            of frames, pulse widths and the shadow handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_gen;

  localparam int F    = 40;
  localparam int MN   = 10;
  localparam int MX   = 20;
  localparam int PW   = 8;
  localparam int SPAN = MX - MN;
  localparam int TP   = 8;   // tick_clk period in in_clk cycles

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          enable    = 1'b0;
  logic          tick_clk  = 1'b0;
  logic [PW-1:0] pos       = '0;
  logic          pos_valid = 1'b0;
  logic          pos_ready;
  logic          servo_pwm;
  logic          frame_start;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .FRAME_TICKS (F),
    .MIN_TICKS   (MN),
    .MAX_TICKS   (MX),
    .POS_WIDTH   (PW)
  ) dut (
    .in_clk      (clk),
    .reset       (rst_n),
    .enable      (enable),
    .tick_clk    (tick_clk),
    .pos         (pos),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .servo_pwm   (servo_pwm),
    .frame_start (frame_start)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int       m_state;      // 0 idle, 1 running
  int       m_cnt;
  int       m_active;
  int       m_shadow;
  bit       m_pending;
  bit       m_pwm;
  bit       m_fs;
  bit [2:0] h;            // tick_clk as seen at the last three edges, [0] newest

  // Stimulus / measurement state
  bit freeze;
  int phase;
  int fs_seen;
  int hi_cnt;
  int exp_hi;
  int last_hi;
  bit meas_ok;

  function automatic int width_of(input int p);
    return MN + (p * SPAN) / (1 << PW);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_cnt     = 0;
    m_active  = MN + SPAN / 2;
    m_shadow  = 0;
    m_pending = 1'b0;
    m_pwm     = 1'b0;
    m_fs      = 1'b0;
    h         = 3'b000;
    meas_ok   = 1'b0;
  endtask

  // A rising edge of tick_clk becomes a counted tick three edges later.
  function automatic bit tick_now();
    return h[1] && !h[2];
  endfunction

  function automatic bit predict_fs();
    return rst_n && enable && tick_now() && (m_state == 0 || m_cnt == F - 1);
  endfunction

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit tk, xfer, fs, pwm_n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk    = tick_now();
    xfer  = pos_valid && !m_pending;
    fs    = 1'b0;
    pwm_n = 1'b0;
    if (!enable) begin
      m_state = 0;
      m_cnt   = 0;
      meas_ok = 1'b0;
    end else begin
      pwm_n = (m_state == 1) && (m_cnt < m_active);
      if (tk) begin
        if (m_state == 0) begin
          m_state = 1; m_cnt = 0; fs = 1'b1;
        end else if (m_cnt == F - 1) begin
          m_cnt = 0; fs = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
    if (fs && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (xfer) begin
      m_shadow  = width_of(int'(pos));
      m_pending = 1'b1;
    end
    m_pwm = pwm_n;
    m_fs  = fs;
    h     = {h[1], h[0], tick_clk};
  endtask

  // One in_clk cycle: drive tick_clk, predict, clock, then compare.
  task automatic step();
    if (!freeze) begin
      phase    = (phase + 1) % TP;
      tick_clk = (phase < TP / 2);
    end
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_val("pwm", 32'(servo_pwm), int'(m_pwm));
    check_val("frame_start", 32'(frame_start), int'(m_fs));
    check_val("pos_ready", 32'(pos_ready), int'(!m_pending));
    if (m_fs) begin
      fs_seen++;
      if (meas_ok) begin
        check_val("frame_hi", hi_cnt, exp_hi);
        last_hi = hi_cnt;
      end
      hi_cnt  = 0;
      exp_hi  = m_active * TP;
      meas_ok = 1'b1;
    end else if (servo_pwm === 1'b1) begin
      hi_cnt++;
    end
  endtask

  task automatic run_frames(input int n);
    int target, budget;
    target  = fs_seen + n;
    budget  = n * F * TP + 200;
    last_hi = -1;
    while (fs_seen < target && budget > 0) begin
      step();
      budget--;
    end
    if (fs_seen < target) check_val("frame_timeout", 0, 1);
  endtask

  task automatic send(input int p);
    pos       = PW'(p);
    pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
  endtask

  initial begin
    int n, r, dut_fs;
    bit prev_rdy;

    freeze  = 1'b1;
    phase   = TP - 1;
    fs_seen = 0;
    hi_cnt  = 0;
    exp_hi  = 0;
    last_hi = -1;
    model_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check_val("rst_pwm", 32'(servo_pwm), 0);
    check_val("rst_fs", 32'(frame_start), 0);
    check_val("rst_ready", 32'(pos_ready), 1);

    // Default width and first frame_start latency
    rst_n  = 1'b1;
    enable = 1'b1;
    freeze = 1'b0;
    phase  = TP - 1;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 20);
    check_val("first_fs_latency", n, 3);
    run_frames(2);
    check_val("default_hi", last_hi, 15 * TP);

    // Extreme positions
    repeat (100) step();
    send(0);
    run_frames(1);
    check_val("pos0_current_frame", last_hi, 15 * TP);
    run_frames(1);
    check_val("pos0_next_frame", last_hi, 10 * TP);
    repeat (50) step();
    send(255);
    run_frames(1);
    check_val("pos255_current_frame", last_hi, 10 * TP);
    run_frames(1);
    check_val("pos255_next_frame", last_hi, 19 * TP);

    // Held valid
    repeat (30) step();
    pos       = 8'd128;
    pos_valid = 1'b1;
    step();
    check_val("ready_drop", 32'(pos_ready), 0);
    prev_rdy = pos_ready;
    n = 0;
    while (frame_start !== 1'b1 && n < 400) begin
      prev_rdy = pos_ready;
      step();
      n++;
    end
    check_val("ready_low_before_fs", 32'(prev_rdy), 0);
    check_val("ready_at_fs", 32'(pos_ready), 1);
    step();
    check_val("ready_retaken", 32'(pos_ready), 0);
    pos_valid = 1'b0;
    run_frames(2);
    check_val("held_valid_hi", last_hi, 15 * TP);

    // Transfer coinciding with a frame start
    n = 0;
    while (!predict_fs() && n < 400) begin
      step();
      n++;
    end
    send(0);
    check_val("boundary_fs", 32'(frame_start), 1);
    check_val("boundary_ready", 32'(pos_ready), 0);
    run_frames(1);
    check_val("boundary_this_frame", last_hi, 15 * TP);
    run_frames(1);
    check_val("boundary_next_frame", last_hi, 10 * TP);

    // Enable drop in the middle of a pulse
    n = 0;
    while (!(m_state == 1 && m_cnt == 5) && n < 400) begin
      step();
      n++;
    end
    check_val("pulse_before_drop", 32'(servo_pwm), 1);
    enable = 1'b0;
    step();
    check_val("enable_drop_pwm", 32'(servo_pwm), 0);
    repeat (20) step();
    enable = 1'b1;
    run_frames(2);
    check_val("reenable_hi", last_hi, 10 * TP);

    // Asynchronous reset mid-pulse with a value pending
    send(255);
    n = 0;
    while (!m_pwm && n < 400) begin
      step();
      n++;
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_val("async_rst_pwm", 32'(servo_pwm), 0);
    check_val("async_rst_ready", 32'(pos_ready), 1);
    check_val("async_rst_fs", 32'(frame_start), 0);
    @(negedge clk);
    repeat (2) step();
    rst_n = 1'b1;
    run_frames(2);
    check_val("after_reset_hi", last_hi, 15 * TP);

    // Stalled tick_clk held high
    n = 0;
    while (tick_clk !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    freeze  = 1'b1;
    meas_ok = 1'b0;
    repeat (5) step();
    dut_fs = 0;
    repeat (200) begin
      step();
      if (frame_start === 1'b1) dut_fs++;
    end
    check_val("stall_no_fs", dut_fs, 0);
    freeze = 1'b0;
    run_frames(2);

    // Randomised traffic against the model
    for (int i = 0; i < 5000; i++) begin
      r         = int'($urandom_range(0, 9));
      pos       = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : (r == 2) ? 8'd128 :
                  PW'($urandom_range(0, 255));
      pos_valid = ($urandom_range(0, 5) == 0);
      enable    = ($urandom_range(0, 999) != 0);
      step();
    end
    pos_valid = 1'b0;
    enable    = 1'b1;
    run_frames(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_servo_pwm_gen
`default_nettype wire

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Servo PWM generator sitting directly downstream of the clock divider. It consumes the divider's square-wave output as a timebase: the wave is synchronised, rising-edge detected, and turned into a one-cycle tick. The block counts ticks into fixed-length frames and drives a servo pulse whose width is set by an 8-bit position value. Position updates are accepted through a valid/ready handshake and applied only at frame boundaries, so a pulse is never truncated or stretched mid-frame.

## Interface
- FRAME_TICKS, 20000: ticks per PWM frame (20 ms at a 1 µs tick).
- MIN_TICKS, 1000: pulse width in ticks for position 0.
- MAX_TICKS, 2000: upper end of the pulse-width span.
- POS_WIDTH, 8: position input width.

- in_clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run request; low forces idle.
- tick_clk  input  1  divider output; sampled in the in_clk domain.
- pos  input  POS_WIDTH  requested servo position.
- pos_valid  input  1  pos is valid this cycle.
- pos_ready  output  1  shadow register free; a transfer occurs when pos_valid and pos_ready are both high.
- servo_pwm  output  1  registered servo drive.
- frame_start  output  1  one-cycle pulse at each frame boundary.

## Operation
- **Derived constant:** SPAN = MAX_TICKS − MIN_TICKS.
- **Width formula:** width = MIN_TICKS + ((pos × SPAN) >> POS_WIDTH).
  - The product is computed at full width, POS_WIDTH + $clog2(SPAN+1) bits, with no truncation before the shift.
  - pos = 2^POS_WIDTH − 1 therefore yields slightly less than MAX_TICKS.
- **Elaboration checks (fatal):** MAX_TICKS > MIN_TICKS and FRAME_TICKS > MAX_TICKS.
- **Frame counter:** frame_cnt is $clog2(FRAME_TICKS) bits and counts 0 … FRAME_TICKS−1.
- **Registers:** width_active (applied width) and shadow_width plus a pending flag (accepted width not yet applied).
- **State IDLE:**
  - frame_cnt = 0 and servo_pwm = 0.
  - On a tick with enable = 1: go to RUN. That tick is a frame start.
- **State RUN:**
  - On each tick: frame_cnt increments.
  - On a tick with frame_cnt = FRAME_TICKS−1: frame_cnt wraps to 0 and this is a frame start.
  - enable = 0 in any cycle: go to IDLE, frame_cnt = 0, servo_pwm = 0 in the next cycle. This takes priority over a tick in the same cycle.
- **Frame start actions:**
  - frame_start pulses for one cycle.
  - If pending: width_active ← shadow_width and pending clears.
- **Pulse generation:** servo_pwm = RUN and frame_cnt < width_active, registered.
- **Handshake:**
  - pos_ready = !pending.
  - On a transfer: shadow_width ← computed width and pending sets.
  - A transfer in the same cycle as a frame start is captured but not applied; it takes effect at the following frame start.
- **Pending across idle:** a pending value persists through IDLE and is applied at the first frame start after re-enable.
- **Missing ticks:** if tick_clk stops toggling, the counter and servo_pwm hold their current values.

## Timing
- **Reset values:**
  - servo_pwm = 0, frame_start = 0, pos_ready = 1.
  - state = IDLE, frame_cnt = 0, pending = 0.
  - width_active = MIN_TICKS + (SPAN >> 1).
- **Reset mid-operation:** all of the above take effect immediately (asynchronously); any pending shadow value is discarded.
- **Tick latency:** the tick is asserted 3 in_clk cycles after a tick_clk rising edge (2-flop synchroniser, then edge compare). It is exactly one cycle wide per rising edge.
- **Counter and frame_start:** frame_cnt and frame_start update on the tick cycle's clock edge.
- **servo_pwm latency:** servo_pwm follows frame_cnt one cycle later. High time per frame is exactly width_active ticks.
- **Tick spacing:** tick_clk high and low phases must each last ≥ 2 in_clk cycles. Faster inputs are out of specification.
- **pos_ready timing:** drops the cycle after a transfer. Rises the cycle after the frame start that applies the shadow value.

## Structure
- **Package servo_pkg:**
  - State enum {IDLE, RUN}.
  - Default FRAME/MIN/MAX constants.
  - Width-computation function.
- **Sub-module tick_sync:**
  - Ports: in_clk, reset, async_in, tick.
  - Contents: 2-flop synchroniser plus rising-edge detector.
  - Reusable for other divider consumers.
- **Top level:** FSM, frame counter, shadow/handshake logic and output registers.

## Test plan
Bench parameters: FRAME_TICKS = 40, MIN_TICKS = 10, MAX_TICKS = 20, POS_WIDTH = 8. tick_clk period is 8 in_clk cycles.
- **Default width:** reset release, enable = 1, no pos → servo_pwm high 15 ticks of every 40. frame_start every 40 ticks; first frame_start 3 cycles after the first tick_clk rise.
- **Extreme positions:** pos = 0 accepted mid-frame → current frame still 15 ticks, next frame 10 ticks. Then pos = 255 → 19 ticks from the following frame.
- **Held valid:** pos_valid held high with pos = 128 during pending → pos_ready low until the cycle after frame_start. A second pos = 128 transfer then gives 15-tick pulses.
- **Boundary transfer:** transfer coinciding with a frame-start cycle → value applied one frame later, not in the frame starting now.
- **Enable drop:** enable dropped at tick 5 of the pulse → servo_pwm low next cycle, frame_cnt = 0. Re-enable → frame_start on the first tick, full pulse width.
- **Async reset and stalled tick:** reset asserted mid-pulse → servo_pwm = 0 and pos_ready = 1 immediately; after release, width returns to 15. tick_clk frozen high → no ticks and outputs hold.
